debouncer_mc: RTL

DEBOUNCER_MC -- requirements
Module: debouncer_mc

---
 rtl/debouncer_mc.sv | 130 +++++++++++++
 1 files changed

// File: rtl/debouncer_mc.sv
// debouncer_mc -- multi-channel switch debouncer.
//
// Each channel first passes its raw input through a short synchroniser
// chain. It then commits a new debounced level once the synchronised value
// has differed from the current output for T+1 consecutive enabled cycles.
// T is the shared runtime threshold.
//
// Ports:
//   i_clk         single clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          count enable; 0 freezes counters/outputs, suppresses pulses
//   iv_input      raw (possibly asynchronous) switch inputs, one per channel
//   iv_threshold  tolerance T shared by all channels
//   ov_output     debounced levels
//   ov_rise       one-cycle pulse on a committed 0->1 change
//   ov_fall       one-cycle pulse on a committed 1->0 change
//   o_any_change  OR of all rise/fall pulses, aligned with them
//   ov_busy       channel counter is nonzero
module debouncer_mc #(
  parameter int                    p_CHANNELS    = 4,
  parameter int                    p_CNT_WIDTH   = 8,
  parameter int                    p_SYNC_STAGES = 2,
  parameter logic [p_CHANNELS-1:0] p_INIT_VALUE  = {p_CHANNELS{1'b0}}
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [p_CHANNELS-1:0]  iv_input,
  input  logic [p_CNT_WIDTH-1:0] iv_threshold,
  output logic [p_CHANNELS-1:0]  ov_output,
  output logic [p_CHANNELS-1:0]  ov_rise,
  output logic [p_CHANNELS-1:0]  ov_fall,
  output logic                   o_any_change,
  output logic [p_CHANNELS-1:0]  ov_busy
);

  // Synchronised input level seen by the debounce logic.
  logic [p_CHANNELS-1:0] sync_level;

  generate
    if (p_SYNC_STAGES == 0) begin : g_no_sync
      assign sync_level = iv_input;
    end else begin : g_sync
      // Power-up contents match the reset contents.
      logic [p_SYNC_STAGES-1:0][p_CHANNELS-1:0] chain = {p_SYNC_STAGES{p_INIT_VALUE}};

      // Synchroniser shift chain; it shifts regardless of i_en.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          chain <= {p_SYNC_STAGES{p_INIT_VALUE}};
        end else begin
          chain[0] <= iv_input;
          for (int k = 1; k < p_SYNC_STAGES; k++) begin
            chain[k] <= chain[k-1];
          end
        end
      end

      assign sync_level = chain[p_SYNC_STAGES-1];
    end
  endgenerate

  // State registers; power-up values equal reset values.
  logic [p_CHANNELS-1:0][p_CNT_WIDTH-1:0] cnt      = {(p_CHANNELS*p_CNT_WIDTH){1'b0}};
  logic [p_CHANNELS-1:0]                  level    = p_INIT_VALUE;
  logic [p_CHANNELS-1:0]                  rise     = {p_CHANNELS{1'b0}};
  logic [p_CHANNELS-1:0]                  fall     = {p_CHANNELS{1'b0}};
  logic [p_CHANNELS-1:0]                  busy     = {p_CHANNELS{1'b0}};
  logic                                   any_chg  = 1'b0;

  logic [p_CHANNELS-1:0][p_CNT_WIDTH-1:0] cnt_nxt;
  logic [p_CHANNELS-1:0]                  level_nxt;
  logic [p_CHANNELS-1:0]                  rise_nxt;
  logic [p_CHANNELS-1:0]                  fall_nxt;
  logic [p_CHANNELS-1:0]                  busy_nxt;

  // Per-channel next-state: clear on agreement, commit once the count has
  // reached T, otherwise count up. The count is bounded by T, so it cannot wrap.
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = {p_CHANNELS{1'b0}};
    fall_nxt  = {p_CHANNELS{1'b0}};
    busy_nxt  = {p_CHANNELS{1'b0}};
    for (int i = 0; i < p_CHANNELS; i++) begin
      if (i_en) begin
        if (sync_level[i] == level[i]) begin
          cnt_nxt[i] = {p_CNT_WIDTH{1'b0}};
        end else if (cnt[i] >= iv_threshold) begin
          // Threshold compare is live, so lowering T can commit immediately.
          level_nxt[i] = sync_level[i];
          cnt_nxt[i]   = {p_CNT_WIDTH{1'b0}};
          rise_nxt[i]  = sync_level[i];
          fall_nxt[i]  = ~sync_level[i];
        end else begin
          cnt_nxt[i] = cnt[i] + p_CNT_WIDTH'(1);
        end
      end else begin
        cnt_nxt[i] = cnt[i];
      end
      busy_nxt[i] = (cnt_nxt[i] != {p_CNT_WIDTH{1'b0}});
    end
  end

  // Register counters, levels and pulses; reset wins over any commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= {(p_CHANNELS*p_CNT_WIDTH){1'b0}};
      level   <= p_INIT_VALUE;
      rise    <= {p_CHANNELS{1'b0}};
      fall    <= {p_CHANNELS{1'b0}};
      busy    <= {p_CHANNELS{1'b0}};
      any_chg <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      level   <= level_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      busy    <= busy_nxt;
      any_chg <= |(rise_nxt | fall_nxt);
    end
  end

  assign ov_output    = level;
  assign ov_rise      = rise;
  assign ov_fall      = fall;
  assign ov_busy      = busy;
  assign o_any_change = any_chg;

endmodule
